// File: rtl/sr_pulse_driver_if.sv
// Bundle of the request, feedback and status signals between the
// command source and sr_pulse_driver.
interface sr_pulse_driver_if #(
    parameter int CNT_W = 8
);
    logic             set_in;
    logic             clr_in;
    logic             q_fb;
    logic             s_out;
    logic             r_out;
    logic             busy;
    logic             conflict;
    logic             err_mismatch;
    logic [CNT_W-1:0] set_cnt;
    logic [CNT_W-1:0] clr_cnt;

    // Request/feedback source side
    modport master (
        output set_in, clr_in, q_fb,
        input  s_out, r_out, busy, conflict, err_mismatch, set_cnt, clr_cnt
    );

    // Pulse driver side
    modport slave (
        input  set_in, clr_in, q_fb,
        output s_out, r_out, busy, conflict, err_mismatch, set_cnt, clr_cnt
    );
endinterface

// File: rtl/sr_pulse_driver.sv
// Command stage for the SR flip-flop: synchronises and debounces the raw
// set/clear request lines, latches rising edges as pending requests,
// arbitrates them and issues spaced single-cycle s/r pulses. Checks q
// feedback after each pulse and counts issued pulses.
module sr_pulse_driver #(
    parameter int DB_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PRIO_SET   = 1,
    parameter int CNT_W      = 8
) (
    input logic              clk,
    input logic              rst,
    sr_pulse_driver_if.slave bus
);

    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    // Bit 0 is the set channel, bit 1 the clear channel throughout.
    logic [1:0]      raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      filt;
    logic [1:0]      filt_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      rise;
    logic [1:0]      pend;
    logic [1:0]      pend_clr;

    state_t          state;
    state_t          state_n;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_n;
    logic            s_q;
    logic            s_n;
    logic            r_q;
    logic            r_n;
    logic            conflict_q;
    logic            conflict_n;
    logic            chk;
    logic            exp_q;
    logic            err_q;
    logic [CNT_W-1:0] set_cnt_q;
    logic [CNT_W-1:0] clr_cnt_q;

    assign raw  = {bus.clr_in, bus.set_in};
    assign rise = filt & ~filt_d;

    // Two-flop synchroniser followed by a per-channel stability filter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            filt    <= '0;
            filt_d  <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            filt_d  <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    // Last differing cycle completes the stable run
                    filt[i]   <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pending requests: set on filtered rising edge, cleared when served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | rise;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next-state, arbitration and pulse decisions
    always_comb begin
        state_n    = state;
        gap_n      = gap_cnt;
        s_n        = 1'b0;
        r_n        = 1'b0;
        conflict_n = 1'b0;
        pend_clr   = 2'b00;
        chk        = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    state_n  = ISSUE;
                    // Clearing every set bit also discards a losing request
                    pend_clr = pend;
                    if (pend == 2'b11) begin
                        conflict_n = 1'b1;
                        if (PRIO_SET != 0) begin
                            s_n = 1'b1;
                        end else begin
                            r_n = 1'b1;
                        end
                    end else begin
                        s_n = pend[0];
                        r_n = pend[1];
                    end
                end
            end
            ISSUE: begin
                state_n = GAP;
                gap_n   = '0;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                    chk     = 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered pulses, pulse counters, expected q and feedback check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            gap_cnt    <= '0;
            exp_q      <= 1'b0;
            err_q      <= 1'b0;
            set_cnt_q  <= '0;
            clr_cnt_q  <= '0;
        end else begin
            s_q        <= s_n;
            r_q        <= r_n;
            conflict_q <= conflict_n;
            gap_cnt    <= gap_n;
            if (state == ISSUE) begin
                if (s_q) begin
                    set_cnt_q <= set_cnt_q + 1'b1;
                    exp_q     <= 1'b1;
                end
                if (r_q) begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    exp_q     <= 1'b0;
                end
            end
            if (chk && (bus.q_fb != exp_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.s_out        = s_q;
    assign bus.r_out        = r_q;
    assign bus.busy         = (state != IDLE);
    assign bus.conflict     = conflict_q;
    assign bus.err_mismatch = err_q;
    assign bus.set_cnt      = set_cnt_q;
    assign bus.clr_cnt      = clr_cnt_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with a model SR flip-flop on q_fb and
// a pulse scoreboard: expected pulses are queued when a request is driven
// and matched when s_out/r_out appear.
module tb_sr_pulse_driver;

    localparam logic [1:0] PS = 2'b10;
    localparam logic [1:0] PR = 2'b01;

    logic clk;
    logic rst;
    logic q_model;
    logic force_q0;
    int   checks;
    int   errors;
    logic [1:0] exp_pulse [$];
    logic [1:0] mon_exp;
    int   s_k;
    int   r_k;

    sr_pulse_driver_if #(.CNT_W(8)) bif ();

    sr_pulse_driver #(
        .DB_CYCLES (4),
        .GAP_CYCLES(2),
        .PRIO_SET  (1),
        .CNT_W     (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model SR flip-flop driven by the pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_model <= 1'b0;
        end else if (bif.s_out) begin
            q_model <= 1'b1;
        end else if (bif.r_out) begin
            q_model <= 1'b0;
        end
    end

    assign bif.q_fb = force_q0 ? 1'b0 : q_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every observed pulse must match the oldest expected one
    always @(negedge clk) begin
        if (rst === 1'b1 && (bif.s_out === 1'b1 || bif.r_out === 1'b1)) begin
            check("s_and_r", 32'(bif.s_out & bif.r_out), 32'd0);
            check("pulse_expected", 32'(exp_pulse.size() != 0), 32'd1);
            if (exp_pulse.size() != 0) begin
                mon_exp = exp_pulse.pop_front();
                check("pulse_kind", 32'({bif.s_out, bif.r_out}), 32'(mon_exp));
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b0;
        bif.set_in = 1'b0;
        bif.clr_in = 1'b0;
        force_q0   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Hold a request high long enough to pass the filter, then release it
    task automatic request(input bit is_set);
        @(posedge clk);
        #1;
        if (is_set) begin
            bif.set_in = 1'b1;
            exp_pulse.push_back(PS);
        end else begin
            bif.clr_in = 1'b1;
            exp_pulse.push_back(PR);
        end
        repeat (10) @(posedge clk);
        #1;
        bif.set_in = 1'b0;
        bif.clr_in = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        s_k      = 0;
        r_k      = 0;
        rst      = 1'b0;
        force_q0 = 1'b0;
        bif.set_in = 1'b0;
        bif.clr_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_out", 32'(bif.s_out), 32'd0);
        check("rst_r_out", 32'(bif.r_out), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_conflict", 32'(bif.conflict), 32'd0);
        check("rst_err", 32'(bif.err_mismatch), 32'd0);
        check("rst_set_cnt", 32'(bif.set_cnt), 32'd0);
        check("rst_clr_cnt", 32'(bif.clr_cnt), 32'd0);
        #1 rst = 1'b1;

        // 1: held set -> one pulse from edge 8 to edge 9
        @(posedge clk);
        #1 bif.set_in = 1'b1;
        exp_pulse.push_back(PS);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("t1_s_out", 32'(bif.s_out), 32'(k == 8));
            check("t1_busy", 32'(bif.busy), 32'(k >= 8 && k <= 10));
        end
        repeat (8) @(posedge clk);
        #1 bif.set_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t1_set_cnt", 32'(bif.set_cnt), 32'd1);
        check("t1_clr_cnt", 32'(bif.clr_cnt), 32'd0);
        check("t1_err", 32'(bif.err_mismatch), 32'd0);

        // 2: 3-cycle glitch is filtered out
        do_reset();
        @(posedge clk);
        #1 bif.set_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 bif.set_in = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("t2_busy", 32'(bif.busy), 32'd0);
        end
        check("t2_set_cnt", 32'(bif.set_cnt), 32'd0);

        // 3: simultaneous requests, set has priority
        do_reset();
        @(posedge clk);
        #1;
        bif.set_in = 1'b1;
        bif.clr_in = 1'b1;
        exp_pulse.push_back(PS);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("t3_conflict", 32'(bif.conflict), 32'(k == 8));
            check("t3_s_out", 32'(bif.s_out), 32'(k == 8));
            check("t3_r_out", 32'(bif.r_out), 32'd0);
        end
        #1;
        bif.set_in = 1'b0;
        bif.clr_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3_set_cnt", 32'(bif.set_cnt), 32'd1);
        check("t3_clr_cnt", 32'(bif.clr_cnt), 32'd0);

        // 4: clear request arriving during GAP is served right after it
        do_reset();
        @(posedge clk);
        #1 bif.set_in = 1'b1;
        exp_pulse.push_back(PS);
        exp_pulse.push_back(PR);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            if (k == 3) #1 bif.clr_in = 1'b1;
            @(negedge clk);
            if (bif.s_out === 1'b1) s_k = k;
            if (bif.r_out === 1'b1) r_k = k;
            check("t4_r_out", 32'(bif.r_out), 32'(k == 12));
        end
        check("t4_spacing", 32'(r_k - s_k >= 4), 32'd1);
        #1;
        bif.set_in = 1'b0;
        bif.clr_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_clr_cnt", 32'(bif.clr_cnt), 32'd1);
        check("t4_err", 32'(bif.err_mismatch), 32'd0);

        // 5: forced q_fb=0 during a set -> sticky mismatch until reset
        do_reset();
        force_q0 = 1'b1;
        @(posedge clk);
        #1 bif.set_in = 1'b1;
        exp_pulse.push_back(PS);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("t5_err", 32'(bif.err_mismatch), 32'(k >= 11));
        end
        #1;
        bif.set_in = 1'b0;
        force_q0   = 1'b0;
        repeat (10) @(posedge clk);
        request(1'b0);
        request(1'b1);
        @(negedge clk);
        check("t5_err_sticky", 32'(bif.err_mismatch), 32'd1);
        check("t5_set_cnt", 32'(bif.set_cnt), 32'd2);
        check("t5_clr_cnt", 32'(bif.clr_cnt), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_err_rst", 32'(bif.err_mismatch), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 6a: reset during ISSUE aborts the pulse
        do_reset();
        @(posedge clk);
        #1 bif.set_in = 1'b1;
        exp_pulse.push_back(PS);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_s_before", 32'(bif.s_out), 32'd1);
        #1;
        rst        = 1'b0;
        bif.set_in = 1'b0;
        #1;
        check("t6_s_abort", 32'(bif.s_out), 32'd0);
        check("t6_busy_abort", 32'(bif.busy), 32'd0);
        check("t6_set_cnt_abort", 32'(bif.set_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6_set_cnt_after", 32'(bif.set_cnt), 32'd0);
        check("t6_busy_after", 32'(bif.busy), 32'd0);

        // 6b: 256 set pulses wrap the 8-bit counter
        for (int n = 0; n < 256; n++) begin
            request(1'b1);
            if (n == 254) begin
                @(negedge clk);
                check("t6_set_cnt_255", 32'(bif.set_cnt), 32'd255);
            end
        end
        @(negedge clk);
        check("t6_set_cnt_wrap", 32'(bif.set_cnt), 32'd0);
        check("t6_clr_cnt", 32'(bif.clr_cnt), 32'd0);
        check("t6_err", 32'(bif.err_mismatch), 32'd0);
        check("sb_drained", 32'(exp_pulse.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
